// File: rtl/alarm_timekeeper.sv
// alarm_timekeeper: BCD 24-hour time of day driven by the interval timer's
// tick, with a programmable alarm, a level interrupt and a 16-bit Avalon-MM
// slave exposing status, control, time and alarm registers.
// Optional build macro ALARM_SNOOZE_EN adds the snooze register at address 6.
module alarm_timekeeper #(
    parameter int TICKS_PER_SEC = 1,
    parameter int SNOOZE_MIN    = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [15:0] PRESCALE_LAST = 16'(TICKS_PER_SEC - 1);

`ifdef ALARM_SNOOZE_EN
    localparam logic [7:0] SNOOZE_BCD = {4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10)};
`endif

    // Register state
    logic        tick_d;
    logic [15:0] prescaler;
    logic [7:0]  sec, min, hour;
    logic [7:0]  al_sec, al_min, al_hour;
    logic        run, alarm_en, irq_en;
    logic        alarm_fired;

    // Next-state values
    logic [15:0] prescaler_nx;
    logic [7:0]  sec_nx, min_nx, hour_nx;
    logic [7:0]  al_sec_nx, al_min_nx, al_hour_nx;
    logic        run_nx, alarm_en_nx, irq_en_nx;
    logic        alarm_fired_nx;
    logic [15:0] readdata_nx;
    logic        irq_nx;

    // Decode and datapath intermediates
    logic        wr_en, wr_status, wr_ctrl, wr_tlo, wr_thi, wr_alo, wr_ahi;
    logic        tick_evt, sec_inc, time_wr, match, fired_clear;
    logic [8:0]  sec_step, min_step, hour_step;
    logic [7:0]  sec_new, min_new, hour_new;

`ifdef ALARM_SNOOZE_EN
    logic        wr_snooze;
    logic [7:0]  snz_sum;
    logic        snz_carry;
    logic [8:0]  snz_hour_step;
    logic [7:0]  snz_min, snz_hour;
`endif

    // Returns the field unchanged if it is valid BCD no greater than max_bcd, else 00
    function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] max_bcd);
        return (v[3:0] <= 4'd9 && v <= max_bcd) ? v : 8'h00;
    endfunction

    // BCD increment of a digit pair that wraps after max_bcd; bit 8 is the carry out
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_bcd);
        if (v == max_bcd)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // Next-state logic: bus decode, prescaler, BCD carry chain, alarm match and read mux
    always_comb begin
        wr_en     = chipselect & ~write_n;
        wr_status = wr_en && (address == 3'd0);
        wr_ctrl   = wr_en && (address == 3'd1);
        wr_tlo    = wr_en && (address == 3'd2);
        wr_thi    = wr_en && (address == 3'd3);
        wr_alo    = wr_en && (address == 3'd4);
        wr_ahi    = wr_en && (address == 3'd5);
        time_wr   = wr_tlo | wr_thi;

        tick_evt  = tick & ~tick_d;
        sec_inc   = run & tick_evt & (prescaler == PRESCALE_LAST);

        prescaler_nx = prescaler;
        if (wr_tlo)
            prescaler_nx = 16'h0000;
        else if (run & tick_evt)
            prescaler_nx = sec_inc ? 16'h0000 : prescaler + 16'd1;

        sec_step  = bcd_inc(sec, 8'h59);
        min_step  = bcd_inc(min, 8'h59);
        hour_step = bcd_inc(hour, 8'h23);
        sec_new   = sec_step[7:0];
        min_new   = sec_step[8] ? min_step[7:0] : min;
        hour_new  = (sec_step[8] & min_step[8]) ? hour_step[7:0] : hour;

        sec_nx  = sec;
        min_nx  = min;
        hour_nx = hour;
        if (time_wr) begin
            if (wr_tlo) begin
                sec_nx = sanitize(writedata[7:0], 8'h59);
                min_nx = sanitize(writedata[15:8], 8'h59);
            end
            if (wr_thi)
                hour_nx = sanitize(writedata[7:0], 8'h23);
        end else if (sec_inc) begin
            sec_nx  = sec_new;
            min_nx  = min_new;
            hour_nx = hour_new;
        end

        al_sec_nx  = al_sec;
        al_min_nx  = al_min;
        al_hour_nx = al_hour;
        if (wr_alo) begin
            al_sec_nx = sanitize(writedata[7:0], 8'h59);
            al_min_nx = sanitize(writedata[15:8], 8'h59);
        end
        if (wr_ahi)
            al_hour_nx = sanitize(writedata[7:0], 8'h23);

        fired_clear = wr_status;

`ifdef ALARM_SNOOZE_EN
        wr_snooze     = wr_en && (address == 3'd6);
        snz_sum       = 8'(al_min[7:4]) * 8'd10 + 8'(al_min[3:0]) + 8'(SNOOZE_MIN);
        snz_carry     = (snz_sum >= 8'd60);
        if (snz_carry)
            snz_sum = snz_sum - 8'd60;
        snz_min       = {4'(snz_sum / 8'd10), 4'(snz_sum % 8'd10)};
        snz_hour_step = bcd_inc(al_hour, 8'h23);
        snz_hour      = snz_carry ? snz_hour_step[7:0] : al_hour;
        if (wr_snooze) begin
            al_min_nx  = snz_min;
            al_hour_nx = snz_hour;
        end
        fired_clear = wr_status | wr_snooze;
`endif

        match = sec_inc & ~time_wr & alarm_en &
                ({hour_new, min_new, sec_new} == {al_hour, al_min, al_sec});

        alarm_fired_nx = alarm_fired;
        if (match)
            alarm_fired_nx = 1'b1;
        else if (fired_clear)
            alarm_fired_nx = 1'b0;

        run_nx      = run;
        alarm_en_nx = alarm_en;
        irq_en_nx   = irq_en;
        if (wr_ctrl) begin
            run_nx      = writedata[0];
            alarm_en_nx = writedata[1];
            irq_en_nx   = writedata[2];
        end

        irq_nx = alarm_fired_nx & irq_en_nx;

        readdata_nx = 16'h0000;
        case (address)
            3'd0: readdata_nx = {14'h0, run, alarm_fired};
            3'd1: readdata_nx = {13'h0, irq_en, alarm_en, run};
            3'd2: readdata_nx = {min, sec};
            3'd3: readdata_nx = {8'h00, hour};
            3'd4: readdata_nx = {al_min, al_sec};
            3'd5: readdata_nx = {8'h00, al_hour};
`ifdef ALARM_SNOOZE_EN
            3'd6: readdata_nx = {8'h00, SNOOZE_BCD};
`endif
            default: readdata_nx = 16'h0000;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_d      <= 1'b0;
            prescaler   <= 16'h0000;
            sec         <= 8'h00;
            min         <= 8'h00;
            hour        <= 8'h00;
            al_sec      <= 8'h00;
            al_min      <= 8'h00;
            al_hour     <= 8'h00;
            run         <= 1'b0;
            alarm_en    <= 1'b0;
            irq_en      <= 1'b0;
            alarm_fired <= 1'b0;
            readdata    <= 16'h0000;
            irq         <= 1'b0;
        end else begin
            tick_d      <= tick;
            prescaler   <= prescaler_nx;
            sec         <= sec_nx;
            min         <= min_nx;
            hour        <= hour_nx;
            al_sec      <= al_sec_nx;
            al_min      <= al_min_nx;
            al_hour     <= al_hour_nx;
            run         <= run_nx;
            alarm_en    <= alarm_en_nx;
            irq_en      <= irq_en_nx;
            alarm_fired <= alarm_fired_nx;
            readdata    <= readdata_nx;
            irq         <= irq_nx;
        end
    end

endmodule
